// File: rtl/mac_pkg.sv
// mac_pkg: shared MAC-array defaults and pointer-width helper
package mac_pkg;
  localparam int COL_DEF = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF = 64;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if: south-edge psum write bus and aligned-row pop bus
interface psum_ofifo_if import mac_pkg::*; #(
  parameter int COL = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF
);
  logic [PSUM_BW*COL-1:0] din;
  logic [COL-1:0] wr;
  logic rd;
  logic [PSUM_BW*COL-1:0] dout;
  logic o_valid;
  logic o_ready;
  logic o_full;
  logic o_ovf;
  modport master (output din, wr, rd, input dout, o_valid, o_ready, o_full, o_ovf);
  modport slave (input din, wr, rd, output dout, o_valid, o_ready, o_full, o_ovf);
endinterface

// File: rtl/psum_ofifo_fifo_col.sv
// fifo_col: single-column synchronous FIFO, no read bypass of same-cycle writes
module fifo_col import mac_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = PSUM_BW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_i,
  input  logic rd_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic full_o,
  output logic empty_o,
  output logic [clog2(DEPTH):0] count_o
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic [AW:0] count_q, count_d;
  logic wr_ok;
  assign full_o = count_q[AW];
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign dout_o = mem_q[rptr_q];
  // a full column still accepts a write when the same cycle pops a slot free
  assign wr_ok = wr_i & (~full_o | rd_i);
  assign wptr_d = wptr_q + AW'(wr_ok);
  assign rptr_d = rptr_q + AW'(rd_i);
  assign count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_i);
  // storage array, not reset: reset only discards contents via the pointers
  always_ff @(posedge clk) if (wr_ok) mem_q[wptr_q] <= din_i;
  // pointer and occupancy state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: re-aligns skewed per-column psums into full rows; optional ReLU via PSUM_OFIFO_RELU_EN
module psum_ofifo import mac_pkg::*; #(
  parameter int COL = COL_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  psum_ofifo_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  logic [COL-1:0] empty, full, col_full;
  logic [PSUM_BW*COL-1:0] head, row_d, out_q;
  logic [AW:0] count [COL];
  logic pop, valid_q, ovf_q, ovf_d;
  assign pop = bus.rd & bus.o_ready;
  genvar c;
  for (c = 0; c < COL; c++) begin : g_col
    fifo_col #(.DEPTH(DEPTH), .W(PSUM_BW)) u_col (
      .clk(clk),
      .reset(reset),
      .wr_i(bus.wr[c]),
      .rd_i(pop),
      .din_i(bus.din[PSUM_BW*c +: PSUM_BW]),
      .dout_o(head[PSUM_BW*c +: PSUM_BW]),
      .full_o(full[c]),
      .empty_o(empty[c]),
      .count_o(count[c])
    );
    assign col_full[c] = count[c][AW];
`ifdef PSUM_OFIFO_RELU_EN
    assign row_d[PSUM_BW*c +: PSUM_BW] = head[PSUM_BW*c+PSUM_BW-1] ? '0 : head[PSUM_BW*c +: PSUM_BW];
`else
    assign row_d[PSUM_BW*c +: PSUM_BW] = head[PSUM_BW*c +: PSUM_BW];
`endif
  end
  assign bus.o_ready = &(~empty);
  assign bus.o_full = |col_full;
  assign ovf_d = ovf_q | (|(bus.wr & full) & ~pop);
  assign bus.dout = out_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ovf = ovf_q;
  // output row register, valid pulse and sticky overflow
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= pop ? row_d : out_q;
      valid_q <= pop;
      ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: queue-model scoreboard plus directed and random stimulus for psum_ofifo
module tb_psum_ofifo;
  localparam int COL = 8;
  localparam int BW = 16;
  localparam int DEPTH = 64;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  psum_ofifo_if #(.COL(COL), .PSUM_BW(BW)) bus();
  psum_ofifo #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [BW-1:0] q [COL][$];
  logic [BW*COL-1:0] m_out = '0;
  logic m_valid = 0, m_ovf = 0, m_rdy, m_full, m_pop;
  logic [BW-1:0] v;
  function automatic logic [BW-1:0] relu(input logic [BW-1:0] x);
`ifdef PSUM_OFIFO_RELU_EN
    return x[BW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction
  task automatic chk(input string name, input logic [BW*COL-1:0] act, input logic [BW*COL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask
  // reference: per-column queues, pop sees only entries present before the edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < COL; c++) q[c].delete();
      m_out = '0;
      m_valid = 0;
      m_ovf = 0;
    end else begin
      m_pop = bus.rd;
      for (int c = 0; c < COL; c++) if (q[c].size() == 0) m_pop = 0;
      m_valid = m_pop;
      if (m_pop) for (int c = 0; c < COL; c++) begin
        v = q[c].pop_front();
        m_out[c*BW +: BW] = relu(v);
      end
      for (int c = 0; c < COL; c++)
        if (bus.wr[c]) begin
          if (q[c].size() < DEPTH) q[c].push_back(bus.din[c*BW +: BW]);
          else m_ovf = 1;
        end
    end
  end
  always @(negedge clk) if (chk_en && reset) begin
    m_rdy = 1;
    m_full = 0;
    for (int c = 0; c < COL; c++) begin
      if (q[c].size() == 0) m_rdy = 0;
      if (q[c].size() == DEPTH) m_full = 1;
    end
    chk("m_ready", {127'b0, bus.o_ready}, {127'b0, m_rdy});
    chk("m_full", {127'b0, bus.o_full}, {127'b0, m_full});
    chk("m_ovf", {127'b0, bus.o_ovf}, {127'b0, m_ovf});
    chk("m_valid", {127'b0, bus.o_valid}, {127'b0, m_valid});
    chk("m_out", bus.dout, m_out);
  end
  task automatic drive(input logic [COL-1:0] w, input logic [BW*COL-1:0] d, input logic r);
    @(negedge clk);
    bus.wr = w;
    bus.din = d;
    bus.rd = r;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.wr = '0;
    bus.rd = 0;
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask
  function automatic logic [BW*COL-1:0] splat(input logic [BW-1:0] x);
    return {COL{x}};
  endfunction
  logic [BW*COL-1:0] d, exp_row;
  int cnt [COL];
  int pulses;
  initial begin
    bus.wr = '0;
    bus.din = '0;
    bus.rd = 0;
    chk_en = 1;
    repeat (2) @(negedge clk);
    reset = 1;
    chk("rst_ready", {127'b0, bus.o_ready}, 128'd0);
    chk("rst_out", bus.dout, '0);
    for (int k = 0; k < 5; k++) drive(8'h01, splat(16'(k + 1)), 0);
    drive(8'h00, '0, 0);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("midrst_ready", {127'b0, bus.o_ready}, 128'd0);
    chk("midrst_ovf", {127'b0, bus.o_ovf}, 128'd0);
    chk("midrst_out", bus.dout, '0);
    @(negedge clk);
    reset = 1;
    drive(8'hFE, splat(16'h1234), 0);
    drive(8'h00, '0, 0);
    chk("col0_empty_ready", {127'b0, bus.o_ready}, 128'd0);
    do_reset();
    for (int c = 0; c < COL; c++) cnt[c] = 0;
    for (int k = 0; k < COL; k++) begin
      for (int c = 0; c < COL; c++) d[c*BW +: BW] = 16'(c * 16 + cnt[c]);
      chk("skew_ready_low", {127'b0, bus.o_ready}, 128'd0);
      drive(8'((1 << (k + 1)) - 1), d, 0);
      for (int c = 0; c <= k; c++) cnt[c]++;
    end
    chk("skew_ready_high", {127'b0, bus.o_ready}, 128'd1);
    drive(8'h00, '0, 1);
    for (int c = 0; c < COL; c++) exp_row[c*BW +: BW] = 16'(c * 16);
    chk("skew_valid", {127'b0, bus.o_valid}, 128'd1);
    chk("skew_row", bus.dout, exp_row);
    do_reset();
    for (int k = 0; k < DEPTH; k++) drive(8'hFF, splat(16'(k)), 0);
    chk("fill_full", {127'b0, bus.o_full}, 128'd1);
    chk("fill_ovf0", {127'b0, bus.o_ovf}, 128'd0);
    drive(8'h08, splat(16'd999), 0);
    chk("drop_ovf", {127'b0, bus.o_ovf}, 128'd1);
    for (int k = 0; k < DEPTH; k++) drive(8'h00, '0, 1);
    chk("drain_last", bus.dout, splat(16'd63));
    chk("drain_ready", {127'b0, bus.o_ready}, 128'd0);
    do_reset();
    for (int k = 0; k < DEPTH; k++) drive(8'hFF, splat(16'(k)), 0);
    drive(8'hFF, splat(16'hA5A5), 1);
    chk("wrrd_full", {127'b0, bus.o_full}, 128'd1);
    chk("wrrd_ovf", {127'b0, bus.o_ovf}, 128'd0);
    chk("wrrd_pop0", bus.dout, splat(16'd0));
    for (int k = 0; k < DEPTH; k++) drive(8'h00, '0, 1);
    chk("wrrd_last", bus.dout, splat(16'hA5A5));
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < COL; c++) d[c*BW +: BW] = 16'(r * 256 + c);
      drive(8'hFF, d, 0);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      drive(8'h00, '0, 1);
      if (bus.o_valid) pulses++;
    end
    for (int c = 0; c < COL; c++) exp_row[c*BW +: BW] = 16'(3 * 256 + c);
    chk("rd10_pulses", 128'(pulses), 128'd4);
    chk("rd10_hold", bus.dout, exp_row);
    do_reset();
    d = '0;
    d[2*BW +: BW] = 16'hFFF6;
    d[5*BW +: BW] = 16'h0007;
    drive(8'hFF, d, 0);
    drive(8'h00, '0, 1);
`ifdef PSUM_OFIFO_RELU_EN
    chk("relu_col2", 128'(bus.dout[2*BW +: BW]), 128'h0);
`else
    chk("raw_col2", 128'(bus.dout[2*BW +: BW]), 128'hFFF6);
`endif
    chk("col5", 128'(bus.dout[5*BW +: BW]), 128'h7);
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < COL; c++) d[c*BW +: BW] = 16'($urandom);
      if ((k / 300) % 2 == 0) drive(8'($urandom | $urandom), d, ($urandom_range(0, 3) == 0));
      else drive(8'($urandom & $urandom), d, ($urandom_range(0, 3) != 0));
    end
    drive(8'h00, '0, 0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
